// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq : registered picoMIPS ALU
//   Single-cycle pass/add/sub, plus an N-cycle shift-add unsigned multiplier
//   that returns either half of the full 2N-bit product.
//
//   clk        rising-edge clock
//   n_reset    synchronous reset, active low
//   start      issue an operation (ignored while busy)
//   func       000 RA, 001 RB, 010 ADD, 011 SUB, 100 MULL, 101 MULH, 11x RA
//   a_sel      00/11 a_in, 01 switches[N-1:0], 10 {N{switches[N]}}
//   b_sel      same coding as a_sel, applied to b_in
//   a_in       register operand A
//   b_in       register operand B
//   switches   external switch inputs (N+1 bits)
//   immediate  instruction immediate
//   imm        1: B operand is the immediate (overrides b_sel)
//   busy       multiply in progress
//   done       one-cycle pulse when result/flags are updated
//   result     registered result, held between done pulses
//   flags      registered {V,N,Z,C}, held between done pulses
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    input  logic [2:0]   func,
    input  logic [1:0]   a_sel,
    input  logic [1:0]   b_sel,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [N:0]   switches,
    input  logic [N-1:0] immediate,
    input  logic         imm,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    localparam int CW = $clog2(N);

    typedef enum logic {IDLE, MUL} state_t;

    state_t          state, state_n;
    logic [N-1:0]    opa, opb;
    logic [N:0]      sum_add, sum_sub;
    logic [N-1:0]    alu_res;
    logic            alu_v, alu_c;
    logic            is_mul;

    logic [2*N-1:0]  acc, acc_n, acc_step;
    logic [2*N-1:0]  mcand, mcand_n;
    logic [N-1:0]    mplier, mplier_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            hi_q, hi_n;
    logic            done_n;
    logic [N-1:0]    result_n;
    logic [3:0]      flags_n;

    function automatic logic [3:0] mk_flags(input logic v, input logic [N-1:0] r,
                                            input logic c);
        return {v, r[N-1], (r == '0), c};
    endfunction

    // Operand selection
    always_comb begin
        case (a_sel)
            2'b01:   opa = switches[N-1:0];
            2'b10:   opa = {N{switches[N]}};
            default: opa = a_in;
        endcase
        if (imm) begin
            opb = immediate;
        end else begin
            case (b_sel)
                2'b01:   opb = switches[N-1:0];
                2'b10:   opb = {N{switches[N]}};
                default: opb = b_in;
            endcase
        end
    end

    // Single-cycle datapath
    assign sum_add = {1'b0, opa} + {1'b0, opb};
    assign sum_sub = {1'b0, opa} + {1'b0, ~opb} + (N+1)'(1);
    assign is_mul  = (func[2:1] == 2'b10);

    always_comb begin
        alu_res = opa;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        case (func)
            3'b001: alu_res = opb;
            3'b010: begin
                alu_res = sum_add[N-1:0];
                alu_c   = sum_add[N];
                alu_v   = (opa[N-1] == opb[N-1]) && (sum_add[N-1] != opa[N-1]);
            end
            3'b011: begin
                alu_res = sum_sub[N-1:0];
                alu_c   = sum_sub[N];
                alu_v   = (opa[N-1] != opb[N-1]) && (sum_sub[N-1] != opa[N-1]);
            end
            default: alu_res = opa;
        endcase
    end

    // One shift-add step: multiplier consumed LSB-first, multiplicand shifts left
    assign acc_step = acc + (mplier[0] ? mcand : '0);

    // Next-state and datapath updates
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
        hi_n     = hi_q;
        done_n   = 1'b0;
        result_n = result;
        flags_n  = flags;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_mul) begin
                        state_n  = MUL;
                        acc_n    = '0;
                        cnt_n    = '0;
                        mcand_n  = {{N{1'b0}}, opa};
                        mplier_n = opb;
                        hi_n     = func[0];
                    end else begin
                        done_n   = 1'b1;
                        result_n = alu_res;
                        flags_n  = mk_flags(alu_v, alu_res, alu_c);
                    end
                end
            end
            MUL: begin
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + CW'(1);
                if (cnt == CW'(N-1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    if (hi_q) begin
                        result_n = acc_step[2*N-1:N];
                        flags_n  = mk_flags(1'b0, acc_step[2*N-1:N], 1'b0);
                    end else begin
                        result_n = acc_step[N-1:0];
                        flags_n  = mk_flags(1'b0, acc_step[N-1:0],
                                            (acc_step[2*N-1:N] != '0));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            hi_q   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            flags  <= '0;
        end else begin
            state  <= state_n;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            cnt    <= cnt_n;
            hi_q   <= hi_n;
            done   <= done_n;
            result <= result_n;
            flags  <= flags_n;
        end
    end

    assign busy = (state == MUL);

endmodule
